// File: rtl/dma_copy_ctrl_if.sv
// ============================================================================
// dma_copy_ctrl_if
// ----------------------------------------------------------------------------
// Purpose:
//   Bundles the control, CPU-handshake and shared-bus signals of the
//   block-copy DMA controller so the controller and its surroundings connect
//   through a single port.
//
// Signals (direction as seen by the DMA controller, modport master):
//   start      in   1-cycle copy request, sampled only while idle
//   src_addr   in   first source address
//   dst_addr   in   first destination address
//   len        in   byte count
//   abort      in   stop after the byte in flight
//   hold_ack   in   CPU has halted and released the buses
//   data_in    in   data bus value during a read cycle
//   hold_req   out  bus request to the CPU (ORed into HLT)
//   addr_out   out  address driven onto the address bus
//   addr_oe    out  DMA owns the address bus
//   mem_oe     out  read strobe
//   mem_we     out  write strobe
//   data_out   out  latched byte driven during a write cycle
//   data_oe    out  DMA drives the data bus
//   busy       out  controller not idle
//   remaining  out  bytes still to copy
//   done       out  1-cycle completion/abort pulse
//   aborted    out  sticky: last transfer ended by abort
//
// Modports:
//   master  the DMA controller
//   slave   the system side (CPU, sequencer, memory)
// ============================================================================
interface dma_copy_ctrl_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] src_addr;
    logic [ADDR_WIDTH-1:0] dst_addr;
    logic [LEN_WIDTH-1:0]  len;
    logic                  abort;
    logic                  hold_ack;
    logic [DATA_WIDTH-1:0] data_in;

    logic                  hold_req;
    logic [ADDR_WIDTH-1:0] addr_out;
    logic                  addr_oe;
    logic                  mem_oe;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_oe;
    logic                  busy;
    logic [LEN_WIDTH-1:0]  remaining;
    logic                  done;
    logic                  aborted;

    modport master (
        input  start, src_addr, dst_addr, len, abort, hold_ack, data_in,
        output hold_req, addr_out, addr_oe, mem_oe, mem_we, data_out,
               data_oe, busy, remaining, done, aborted
    );

    modport slave (
        output start, src_addr, dst_addr, len, abort, hold_ack, data_in,
        input  hold_req, addr_out, addr_oe, mem_oe, mem_we, data_out,
               data_oe, busy, remaining, done, aborted
    );
endinterface

// File: rtl/dma_copy_ctrl.sv
// ============================================================================
// dma_copy_ctrl
// ----------------------------------------------------------------------------
// Purpose:
//   Block-copy DMA controller acting as a second bus master next to the CPU
//   control unit. On start it requests the buses (hold_req), waits for
//   hold_ack, then copies len bytes from src to dst, one read cycle followed
//   by one write cycle per byte, releases the buses and pulses done.
//   Pointers wrap modulo 2**ADDR_WIDTH.
//
// Ports:
//   clk    system clock, all state on the rising edge
//   reset  synchronous, active-high; returns to IDLE with all outputs 0
//   bus    dma_copy_ctrl_if.master: control inputs, CPU handshake, shared
//          address/data bus drives and status outputs
//
// State sequence: IDLE -> REQ -> (READ -> WRITE)* -> RELEASE -> IDLE
//   All bus strobes are registered decodes of the next state, so they are
//   glitch-free and line up exactly with the state they belong to.
// ============================================================================
module dma_copy_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic          clk,
    input  logic          reset,
    dma_copy_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_READ,
        S_WRITE,
        S_RELEASE
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic [ADDR_WIDTH-1:0] src_ptr;
    logic [ADDR_WIDTH-1:0] dst_ptr;
    logic [ADDR_WIDTH-1:0] src_inc;
    logic [ADDR_WIDTH-1:0] dst_inc;
    logic [DATA_WIDTH-1:0] data_latch;
    logic [LEN_WIDTH-1:0]  remaining_q;

    // Abort seen during READ is remembered so that it still ends the
    // transfer once the byte in flight has been written.
    logic                  abort_pend;

    logic                  accept;
    logic                  go_abort;
    logic                  last_byte;

    assign src_inc   = src_ptr + 1'b1;
    assign dst_inc   = dst_ptr + 1'b1;
    assign last_byte = (remaining_q == LEN_WIDTH'(1));

    assign bus.data_out  = data_latch;
    assign bus.remaining = remaining_q;

    // ------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        go_abort  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    // A zero-length request never touches the bus.
                    state_nxt = (bus.len != '0) ? S_REQ : S_RELEASE;
                end
            end
            S_REQ: begin
                // Abort wins over a simultaneous grant.
                if (bus.abort) begin
                    state_nxt = S_RELEASE;
                    go_abort  = 1'b1;
                end else if (bus.hold_ack) begin
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                // A byte is never split: READ always completes into WRITE.
                state_nxt = S_WRITE;
            end
            S_WRITE: begin
                // Finishing the last byte counts as normal completion even
                // if abort arrives on that same byte.
                if (last_byte) begin
                    state_nxt = S_RELEASE;
                end else if (bus.abort || abort_pend) begin
                    state_nxt = S_RELEASE;
                    go_abort  = 1'b1;
                end else begin
                    state_nxt = S_READ;
                end
            end
            S_RELEASE: begin
                // hold_ack is deliberately not waited on here.
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            src_ptr      <= '0;
            dst_ptr      <= '0;
            data_latch   <= '0;
            remaining_q  <= '0;
            abort_pend   <= 1'b0;
            bus.hold_req <= 1'b0;
            bus.addr_out <= '0;
            bus.addr_oe  <= 1'b0;
            bus.mem_oe   <= 1'b0;
            bus.mem_we   <= 1'b0;
            bus.data_oe  <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.aborted  <= 1'b0;
        end else begin
            state <= state_nxt;

            // Bus drives are confined to READ/WRITE so the DMA never fights
            // the CPU drivers in IDLE, REQ or RELEASE.
            bus.hold_req <= (state_nxt == S_REQ) || (state_nxt == S_READ) ||
                            (state_nxt == S_WRITE);
            bus.addr_oe  <= (state_nxt == S_READ) || (state_nxt == S_WRITE);
            bus.mem_oe   <= (state_nxt == S_READ);
            bus.mem_we   <= (state_nxt == S_WRITE);
            bus.data_oe  <= (state_nxt == S_WRITE);
            bus.busy     <= (state_nxt != S_IDLE);
            bus.done     <= (state_nxt == S_RELEASE);

            // The address register is loaded with the pointer that will be
            // current during the next state; on WRITE->READ the source
            // pointer is being incremented on this very edge.
            case (state_nxt)
                S_READ:  bus.addr_out <= (state == S_WRITE) ? src_inc : src_ptr;
                S_WRITE: bus.addr_out <= dst_ptr;
                default: bus.addr_out <= '0;
            endcase

            if (accept) begin
                src_ptr     <= bus.src_addr;
                dst_ptr     <= bus.dst_addr;
                remaining_q <= bus.len;
                bus.aborted <= 1'b0;
            end

            if (go_abort) begin
                bus.aborted <= 1'b1;
            end

            if (state == S_READ) begin
                data_latch <= bus.data_in;
                abort_pend <= bus.abort;
            end else begin
                abort_pend <= 1'b0;
            end

            if (state == S_WRITE) begin
                src_ptr     <= src_inc;
                dst_ptr     <= dst_inc;
                remaining_q <= remaining_q - 1'b1;
            end
        end
    end

endmodule
